// File: rtl/seg7_capture.sv
// Debounced seven-segment pattern capture: samples a segment bus, waits for a stable pattern and reports its hex digit once.
// Optional saturating illegal-report counter enabled with macro SEG7_ERR_CNT_EN.
module seg7_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] segment,
  input  logic       enable,
  input  logic       ready,
  output logic [3:0] digit,
  output logic       valid,
  output logic       illegal
`ifdef SEG7_ERR_CNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam int unsigned SEG_W = 7;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned ERR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_PRESENT,
    ST_LOCKED
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SEG_W-1:0]   r_s;
  logic [SEG_W-1:0]   r_cap;
  logic [SEG_W-1:0]   w_cap_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_load;
  logic [3:0]         r_digit;
  logic               r_illegal;
  logic               r_valid;
  logic [4:0]         w_dec;

  // {illegal, digit} for a captured pattern; anything outside the table is illegal with digit 0
  function automatic logic [4:0] decode(input logic [SEG_W-1:0] p);
    case (p)
      7'h7E:   decode = {1'b0, 4'h0};
      7'h30:   decode = {1'b0, 4'h1};
      7'h6D:   decode = {1'b0, 4'h2};
      7'h79:   decode = {1'b0, 4'h3};
      7'h33:   decode = {1'b0, 4'h4};
      7'h5B:   decode = {1'b0, 4'h5};
      7'h5F:   decode = {1'b0, 4'h6};
      7'h70:   decode = {1'b0, 4'h7};
      7'h7F:   decode = {1'b0, 4'h8};
      7'h7B:   decode = {1'b0, 4'h9};
      7'h77:   decode = {1'b0, 4'hA};
      7'h1F:   decode = {1'b0, 4'hB};
      7'h4E:   decode = {1'b0, 4'hC};
      7'h3D:   decode = {1'b0, 4'hD};
      7'h4F:   decode = {1'b0, 4'hE};
      7'h47:   decode = {1'b0, 4'hF};
      default: decode = {1'b1, 4'h0};
    endcase
  endfunction

  assign w_dec = decode(r_cap);

  // State register and datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_s       <= '0;
      r_cap     <= '0;
      r_cnt     <= '0;
      r_digit   <= '0;
      r_illegal <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= segment;
      r_cap   <= w_cap_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= (w_state_nxt == ST_PRESENT);
      if (w_load) begin
        r_digit   <= w_dec[3:0];
        r_illegal <= w_dec[4];
      end
    end
  end

  // Next-state logic; enable low overrides every state
  always_comb begin
    w_state_nxt = r_state;
    w_cap_nxt   = r_cap;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    if (!enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_s != '0) begin
            w_cap_nxt   = r_s;
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (r_s == '0) begin
            w_state_nxt = ST_IDLE;
          end else if (r_s != r_cap) begin
            w_cap_nxt = r_s;
            w_cnt_nxt = CNT_W'(1);
          end else if (r_cnt < CNT_W'(STABLE_CYCLES)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end else begin
            w_load      = 1'b1;
            w_state_nxt = ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (ready) w_state_nxt = ST_LOCKED;
        end
        ST_LOCKED: begin
          if (r_s == '0) begin
            w_state_nxt = ST_IDLE;
          end else if (r_s != r_cap) begin
            w_cap_nxt   = r_s;
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = ST_SETTLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign digit   = r_digit;
  assign valid   = r_valid;
  assign illegal = r_illegal;

`ifdef SEG7_ERR_CNT_EN
  logic [ERR_W-1:0] r_err_count;

  // Saturating count of accepted illegal reports
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count <= '0;
    end else if (r_valid && ready && r_illegal && (r_err_count != {ERR_W{1'b1}})) begin
      r_err_count <= r_err_count + ERR_W'(1);
    end
  end

  assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_seg7_capture.sv
// Directed self-checking bench for seg7_capture with default STABLE_CYCLES (report after edge 6).
// Counter checks are compiled in when SEG7_ERR_CNT_EN is defined.
module tb_seg7_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] segment = '0;
  logic       enable = 1'b0;
  logic       ready = 1'b0;
  logic [3:0] digit;
  logic       valid;
  logic       illegal;
`ifdef SEG7_ERR_CNT_EN
  logic [7:0] err_count;
`endif

  int total = 0;
  int bad   = 0;

  seg7_capture #(.STABLE_CYCLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .segment  (segment),
    .enable   (enable),
    .ready    (ready),
    .digit    (digit),
    .valid    (valid),
    .illegal  (illegal)
`ifdef SEG7_ERR_CNT_EN
    ,
    .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Blank the bus long enough for the block to return to IDLE
  task automatic go_idle();
    segment = 7'h00;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++;
    if (valid !== 1'b0 || digit !== 4'h0 || illegal !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got valid=%b digit=%h illegal=%b, need 0/0/0", valid, digit, illegal);
    end
`ifdef SEG7_ERR_CNT_EN
    total++;
    if (err_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_err_count: got %0d need 0", err_count);
    end
`endif
    repeat (2) tick();
    rst = 1'b0;
    enable = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic exp_v;
    int   hi_cnt;
    ready = 1'b1;
    segment = 7'h6D;
    for (int e = 1; e <= 6; e++) begin
      tick();
      exp_v = (e == 6);
      total++;
      if (valid !== exp_v) begin
        bad++;
        $display("FAIL basic_latency edge %0d: got valid=%b need %b", e, valid, exp_v);
      end
    end
    total++;
    if (digit !== 4'h2 || illegal !== 1'b0) begin
      bad++;
      $display("FAIL basic_digit: got digit=%h illegal=%b need 2/0", digit, illegal);
    end
    hi_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (valid === 1'b1) hi_cnt++;
    end
    total++;
    if (hi_cnt != 0) begin
      bad++;
      $display("FAIL basic_single_report: got %0d extra valid cycles need 0", hi_cnt);
    end
    go_idle();
  endtask

  task automatic test_toggle();
    logic [6:0] pat [10];
    logic       exp_v;
    int         hi_cnt;
    pat = '{7'h30, 7'h30, 7'h79, 7'h79, 7'h30, 7'h30, 7'h79, 7'h79, 7'h30, 7'h30};
    ready = 1'b1;
    hi_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      segment = pat[i];
      tick();
      if (valid === 1'b1) hi_cnt++;
    end
    total++;
    if (hi_cnt != 0) begin
      bad++;
      $display("FAIL toggle_no_valid: got %0d valid cycles need 0", hi_cnt);
    end
    segment = 7'h79;
    for (int e = 1; e <= 6; e++) begin
      tick();
      exp_v = (e == 6);
      total++;
      if (valid !== exp_v) begin
        bad++;
        $display("FAIL toggle_latency edge %0d: got valid=%b need %b", e, valid, exp_v);
      end
    end
    total++;
    if (digit !== 4'h3 || illegal !== 1'b0) begin
      bad++;
      $display("FAIL toggle_digit: got digit=%h illegal=%b need 3/0", digit, illegal);
    end
    go_idle();
  endtask

  task automatic test_backpressure();
    logic exp_v;
    int   drop;
    ready = 1'b0;
    segment = 7'h47;
    repeat (6) tick();
    total++;
    if (valid !== 1'b1 || digit !== 4'hF) begin
      bad++;
      $display("FAIL bp_present: got valid=%b digit=%h need 1/F", valid, digit);
    end
    segment = 7'h7E;
    drop = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (valid !== 1'b1 || digit !== 4'hF || illegal !== 1'b0) drop++;
    end
    total++;
    if (drop != 0) begin
      bad++;
      $display("FAIL bp_hold: got %0d cycles with valid/digit disturbed need 0", drop);
    end
    ready = 1'b1;
    tick();
    total++;
    if (valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_accept: got valid=%b need 0", valid);
    end
    for (int e = 1; e <= 5; e++) begin
      tick();
      exp_v = (e == 5);
      total++;
      if (valid !== exp_v) begin
        bad++;
        $display("FAIL bp_next_latency edge %0d: got valid=%b need %b", e, valid, exp_v);
      end
    end
    total++;
    if (digit !== 4'h0 || illegal !== 1'b0) begin
      bad++;
      $display("FAIL bp_next_digit: got digit=%h illegal=%b need 0/0", digit, illegal);
    end
    go_idle();
  endtask

  task automatic test_illegal();
    ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      segment = 7'h01;
      repeat (6) tick();
      total++;
      if (valid !== 1'b1 || illegal !== 1'b1 || digit !== 4'h0) begin
        bad++;
        $display("FAIL illegal_report %0d: got valid=%b illegal=%b digit=%h need 1/1/0", r, valid, illegal, digit);
      end
      tick();
      segment = 7'h00;
      repeat (2) tick();
    end
`ifdef SEG7_ERR_CNT_EN
    total++;
    if (err_count !== 8'd2) begin
      bad++;
      $display("FAIL err_count_two: got %0d need 2", err_count);
    end
    for (int r = 0; r < 298; r++) begin
      segment = 7'h01;
      repeat (7) tick();
      segment = 7'h00;
      repeat (2) tick();
    end
    total++;
    if (err_count !== 8'd255) begin
      bad++;
      $display("FAIL err_count_saturate: got %0d need 255", err_count);
    end
`endif
    go_idle();
  endtask

  task automatic test_enable_abort();
    ready = 1'b0;
    segment = 7'h5B;
    repeat (6) tick();
    total++;
    if (valid !== 1'b1 || digit !== 4'h5) begin
      bad++;
      $display("FAIL abort_present: got valid=%b digit=%h need 1/5", valid, digit);
    end
    enable = 1'b0;
    tick();
    total++;
    if (valid !== 1'b0 || digit !== 4'h5) begin
      bad++;
      $display("FAIL abort_drop: got valid=%b digit=%h need 0/5", valid, digit);
    end
    enable = 1'b1;
    repeat (5) tick();
    total++;
    if (valid !== 1'b1 || digit !== 4'h5) begin
      bad++;
      $display("FAIL abort_restart: got valid=%b digit=%h need 1/5", valid, digit);
    end
    ready = 1'b1;
    tick();
    go_idle();
  endtask

  task automatic test_reset_mid_settle();
    logic exp_v;
    ready = 1'b1;
    segment = 7'h4F;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    total++;
    if (valid !== 1'b0 || digit !== 4'h0 || illegal !== 1'b0) begin
      bad++;
      $display("FAIL rst_async: got valid=%b digit=%h illegal=%b need 0/0/0", valid, digit, illegal);
    end
`ifdef SEG7_ERR_CNT_EN
    total++;
    if (err_count !== 8'd0) begin
      bad++;
      $display("FAIL rst_err_count: got %0d need 0", err_count);
    end
`endif
    #1;
    rst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      exp_v = (e == 6);
      total++;
      if (valid !== exp_v) begin
        bad++;
        $display("FAIL rst_restart_latency edge %0d: got valid=%b need %b", e, valid, exp_v);
      end
    end
    total++;
    if (digit !== 4'hE || illegal !== 1'b0) begin
      bad++;
      $display("FAIL rst_restart_digit: got digit=%h illegal=%b need E/0", digit, illegal);
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_backpressure();
    test_illegal();
    test_enable_abort();
    test_reset_mid_settle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_capture.md
SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, consecutive matching samples required before a pattern is reported; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 segment  input  7  segment pattern {a,b,c,d,e,f,g}, a = bit 6, active-high, 7'b0000000 = blank.
REQ-005 enable  input  1  capture enable; 0 aborts and idles the block.
REQ-006 ready  input  1  consumer accepts the current digit when high with valid.
REQ-007 digit  output  4  decoded hex value of the captured pattern.
REQ-008 valid  output  1  digit/illegal hold a report awaiting acceptance.
REQ-009 illegal  output  1  captured pattern is nonzero but not in the decode table.
REQ-010 err_count  output  8  saturating count of accepted illegal reports; present only with SEG7_ERR_CNT_EN.

Function
REQ-011 segment shall be registered every cycle into a sample register s; all decisions use s, never segment directly.
REQ-012 Decode table (s -> digit): 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9, 77->A, 1F->B, 4E->C, 3D->D, 4F->E, 47->F (hex values of s).
REQ-013 Any other nonzero s shall report digit=0 with illegal=1.
REQ-014 FSM states: IDLE, SETTLE, PRESENT, LOCKED.
REQ-015 IDLE: if enable=1 and s!=0, load cap=s, cnt=1, go to SETTLE; otherwise stay.
REQ-016 SETTLE: s==0 -> IDLE; s!=cap -> cap=s, cnt=1, stay; s==cap and cnt<STABLE_CYCLES -> cnt+1; s==cap and cnt==STABLE_CYCLES -> register digit/illegal from cap, go to PRESENT.
REQ-017 PRESENT: valid=1; digit and illegal shall not change; ready=1 -> LOCKED with valid=0 next cycle; changes on s are ignored.
REQ-018 LOCKED: stay while s==cap; s==0 -> IDLE; s!=cap and s!=0 -> cap=s, cnt=1, go to SETTLE; the same pattern is never reported twice without an intervening change.
REQ-019 Latency: counting the first edge at which a new stable pattern is on segment as edge 1, valid shall rise after edge STABLE_CYCLES+2 (edge 6 for default).
REQ-020 valid shall be 1 only in PRESENT; digit/illegal shall retain their last value outside PRESENT.
REQ-021 enable=0 in any state shall force IDLE at the next edge; valid drops even if unaccepted; report is discarded.
REQ-022 ready while valid=0 shall have no effect.

Reset
REQ-023 rst=1 shall immediately force state=IDLE, valid=0, digit=0, illegal=0, s=0, cap=0, cnt=0, err_count=0, independent of clk.
REQ-024 Reset asserted mid-SETTLE or mid-PRESENT shall discard the pending report; after release capture restarts from IDLE.

Configuration
REQ-025 Macro SEG7_ERR_CNT_EN defined: err_count port exists, increments by 1 on each accepted (valid&ready) report with illegal=1, saturates at 255, cleared only by rst.
REQ-026 Macro SEG7_ERR_CNT_EN undefined: no err_count port, no counter logic; all other behaviour identical.

Verification
REQ-027 enable=1, segment=7'h6D held, ready=1 -> valid high after edge 6 for exactly one cycle, digit=2, illegal=0, no second report while 7'h6D held.
REQ-028 segment toggles 7'h30/7'h79 every 2 cycles, then held 7'h79 -> no valid during toggling; valid with digit=3 at edge 6 after final change.
REQ-029 segment=7'h01 stable, ready=1 twice with a blank between, SEG7_ERR_CNT_EN defined -> two reports with illegal=1, digit=0, err_count=2; 300 such reports -> err_count=255.
REQ-030 segment=7'h47 reported, ready=0 for 10 cycles while segment changes to 7'h7E -> valid stays high, digit=F throughout; ready=1 -> accepted, then 7'h7E reported as digit=0.
REQ-031 Mid-PRESENT: enable=0 for one cycle -> valid low next edge; rst pulse mid-SETTLE (between edges, no clock) -> outputs zero immediately; capture restarts with full STABLE_CYCLES+2 latency.
